seq_div: RTL and testbench
==========================

# seq_div

Iterative restoring divider for the multicycle CPU: takes operand registers A and B (`rs` and `rt`) and produces the quotient for LO and the remainder for HI. It is started by the control FSM and sits directly upstream of the HI/LO register pair. It raises a one-cycle `done` that the FSM waits on before asserting HIWrite/LOWrite. It retires one quotient bit per clock.

## Interface
- `WIDTH`, 32: operand and result width in bits.
- `clk`  in  1  system clock, all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  request a division; level-tolerant, see Operation.
- `a`  in  WIDTH  dividend, sampled on the accepting edge only.
- `b`  in  WIDTH  divisor, sampled on the accepting edge only.
- `quotient`  out  WIDTH  result for LO; held until the next completion.
- `remainder`  out  WIDTH  result for HI; held until the next completion.
- `done`  out  1  one-cycle completion pulse; results valid in the same cycle.
- `div_by_zero`  out  1  set on a completion with `b == 0`; held until the next completion.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States and transitions:**
  - IDLE → ITER on accept.
  - ITER → FIX after WIDTH steps.
  - FIX → DONE.
  - DONE → IDLE.
  - IDLE → DONE directly when `b == 0`.
- **Accept condition:** `start` high in IDLE with the internal `armed` bit set.
  - `armed` is cleared on accept and set in any cycle where `start` is low.
  - A held `start` therefore launches exactly one operation.
- `start` outside IDLE is ignored; an operation is never restarted.
- **Load:** on accept, capture |a| into the dividend/quotient shift register and |b| into the divisor register. Latch `sa = a[WIDTH-1]` and `sq = a[WIDTH-1] ^ b[WIDTH-1]`. Clear the partial remainder (WIDTH+1 bits).
- **ITER step:** shift {rem, dq} left by 1, then trial subtract `rem - divisor`.
  - Non-negative: keep the difference and set the quotient LSB to 1.
  - Negative: restore and set the LSB to 0.
  - The step counter runs 0..WIDTH-1.
- **FIX:**
  - `quotient = sq ? -q : q`
  - `remainder = sa ? -r : r`
  - Truncation toward zero; remainder takes the sign of the dividend.
  - Then `done = 1` and `div_by_zero = 0`.
- **Overflow:** -2^(WIDTH-1) / -1 gives quotient 0x80000000, remainder 0, no flag. Magnitudes are handled as WIDTH-bit unsigned, so no special case is needed.
- **Zero divisor:**
  - Outputs `quotient = 0`, `remainder = a`, `div_by_zero = 1`, `done = 1`.
  - No iterations run.
- **Reset values (asynchronous, any state including mid-operation):**
  - state IDLE, `armed = 1`.
  - `quotient`, `remainder`, `done`, `div_by_zero`, `busy` all 0.
  - Any in-flight result is discarded.

## Timing
- Edge E0 is the accepting edge.
- **Normal case:**
  - Iterations occur on E1..E32 (WIDTH edges).
  - FIX on E33 writes outputs and raises `done`.
  - `done` is high for the cycle E33–E34 and low after E34, when the state returns to IDLE.
  - Latency from the accepting edge to `done` is WIDTH+1 edges.
- **Zero divisor:** outputs and `done` are written on E0; `done` is high for E0–E1.
- **Next accept:** earliest at E35 (normal case), and only if `start` was low for at least one cycle after E0.
- **Stability:** `busy` rises after E0 and falls after the DONE cycle. Outputs never change while `busy` is high except on the completion edge.

## Configuration
- `SEQ_DIV_SIGNED_EN` defined: signed MIPS `div` semantics as above.
- `SEQ_DIV_SIGNED_EN` undefined: unsigned only.
  - No abs/negate logic and no FIX state; ITER → DONE.
  - Outputs are written on the last iteration edge E32, so latency is WIDTH edges.
  - Zero-divisor behaviour is unchanged.

## Structure
- **Package `seq_div_pkg`:**
  - State enum (IDLE, ITER, FIX, DONE).
  - `SEQ_DIV_WIDTH = 32`.
  - Step-counter width `$clog2(WIDTH)`.
  - Latency constants for both configurations.
- **Sub-module `seq_div_step`:** one combinational restoring step. Takes {rem, dq, divisor} and returns the next {rem, dq}. This keeps the FSM file free of arithmetic and lets the step be unit-tested.

## Test plan
- `a = 100`, `b = 7`, one-cycle `start` → `quotient = 14`, `remainder = 2`, `done` high exactly in E33–E34, `div_by_zero = 0`.
- `a = -7`, `b = 2` → `quotient = 0xFFFFFFFD`, `remainder = 0xFFFFFFFF`; `a = 7`, `b = -2` → `quotient = 0xFFFFFFFD`, `remainder = 1`.
- `a = 0x80000000`, `b = 0xFFFFFFFF` → `quotient = 0x80000000`, `remainder = 0`, `div_by_zero = 0`.
- `a = 5`, `b = 0` → `done` in E0–E1, `quotient = 0`, `remainder = 5`, `div_by_zero = 1`.
  - A following `a = 9`, `b = 3` → `quotient = 3`, `div_by_zero = 0`.
- `start` held high for 80 cycles with `a = 50`, `b = 5` → exactly one `done` pulse (E33); `start` toggling while `busy` → no effect.
- `reset` low at iteration 10, released, then `a = 1000`, `b = 10` → all outputs 0 during and after reset; next result `quotient = 100`, `remainder = 0`, no stale `done`.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the seq_div iterative divider.
// Latency constants cover both builds (SEQ_DIV_SIGNED_EN defined / undefined).
package seq_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int SEQ_DIV_WIDTH = 32;
    localparam int SEQ_DIV_CNT_W = $clog2(SEQ_DIV_WIDTH);

    // Edges from the accepting edge to the completion edge.
    localparam int SEQ_DIV_LAT_SIGNED   = SEQ_DIV_WIDTH + 1;
    localparam int SEQ_DIV_LAT_UNSIGNED = SEQ_DIV_WIDTH;

endpackage

// File: rtl/seq_div_if.sv
// Request/result bundle between the control FSM (master) and seq_div (slave).
interface seq_div_if #(
    parameter int WIDTH = seq_div_pkg::SEQ_DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output start, a, b,
        input  quotient, remainder, done, div_by_zero, busy
    );

    modport slave (
        input  start, a, b,
        output quotient, remainder, done, div_by_zero, busy
    );
endinterface

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift {rem, dq} left, trial subtract.
module seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dq_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] dq_o
);
    logic [WIDTH:0]          rem_sh;
    logic [WIDTH-1:0]        dq_sh;
    logic signed [WIDTH+1:0] diff;

    assign rem_sh = {rem_i[WIDTH-1:0], dq_i[WIDTH-1]};
    assign dq_sh  = {dq_i[WIDTH-2:0], 1'b0};
    // One extra bit so the sign of the trial difference is never lost.
    assign diff   = $signed({1'b0, rem_sh}) - $signed({2'b00, div_i});

    always_comb begin
        rem_o = rem_sh;
        dq_o  = dq_sh;
        if (diff >= 0) begin
            rem_o = diff[WIDTH:0];
            dq_o  = {dq_sh[WIDTH-1:1], 1'b1};
        end
    end
endmodule

// File: rtl/seq_div.sv
// Iterative restoring divider feeding HI (remainder) / LO (quotient), one bit per clock.
// SEQ_DIV_SIGNED_EN defined: signed div with FIX state; undefined: unsigned only.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    seq_div_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_dq;

`ifdef SEQ_DIV_SIGNED_EN
    logic sa_q, sa_d;
    logic sq_q, sq_d;

    // Magnitude as WIDTH-bit unsigned; -2^(WIDTH-1) maps onto itself correctly.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction
`endif

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dq_i  (dq_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .dq_o  (step_dq)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b1;
            cnt_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        dq_q  <= dq_d;
        div_q <= div_d;
`ifdef SEQ_DIV_SIGNED_EN
        sa_q  <= sa_d;
        sq_q  <= sq_d;
`endif
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        div_d   = div_q;
`ifdef SEQ_DIV_SIGNED_EN
        sa_d    = sa_q;
        sq_d    = sq_q;
`endif
        // A held start re-arms only after it has been seen low.
        if (!bus.start) armed_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && armed_q) begin
                    armed_d = 1'b0;
                    if (bus.b == '0) begin
                        quot_d  = '0;
                        remd_d  = bus.a;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
`ifdef SEQ_DIV_SIGNED_EN
                        dq_d  = mag(bus.a);
                        div_d = mag(bus.b);
                        sa_d  = bus.a[WIDTH-1];
                        sq_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`else
                        dq_d  = bus.a;
                        div_d = bus.b;
`endif
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                rem_d = step_rem;
                dq_d  = step_dq;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SEQ_DIV_SIGNED_EN
                    state_d = ST_FIX;
`else
                    quot_d  = step_dq;
                    remd_d  = step_rem[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
`endif
                end
            end
            ST_FIX: begin
`ifdef SEQ_DIV_SIGNED_EN
                quot_d = sq_q ? -dq_q : dq_q;
                remd_d = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
`endif
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = remd_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div with a result scoreboard; follows SEQ_DIV_SIGNED_EN like the RTL.
module tb_seq_div;
    import seq_div_pkg::*;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } res_t;

`ifdef SEQ_DIV_SIGNED_EN
    localparam int LAT = SEQ_DIV_LAT_SIGNED;
`else
    localparam int LAT = SEQ_DIV_LAT_UNSIGNED;
`endif

    logic clk;
    logic reset;
    int   total;
    int   passed;
    res_t sb[$];

    seq_div_if #(.WIDTH(32)) bus ();

    seq_div #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t        res;
        logic [31:0] ma, mb, qm, rm;
        if (b == 32'd0) begin
            res.q   = 32'd0;
            res.r   = a;
            res.dbz = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            ma = a[31] ? (~a + 32'd1) : a;
            mb = b[31] ? (~b + 32'd1) : b;
            qm = ma / mb;
            rm = ma % mb;
            res.q = (a[31] ^ b[31]) ? (~qm + 32'd1) : qm;
            res.r = a[31] ? (~rm + 32'd1) : rm;
`else
            ma = a;
            mb = b;
            qm = ma / mb;
            rm = ma % mb;
            res.q = qm;
            res.r = rm;
`endif
            res.dbz = 1'b0;
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // mode 0: one-cycle start, 1: start held high, 2: start toggled while busy
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input int mode);
        res_t exp;
        int   lat;
        int   e;
        bit   seen;
        sb.push_back(model(a, b));
        lat  = (b == 32'd0) ? 0 : LAT;
        seen = 1'b0;
        e    = -1;
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                e    = i;
                break;
            end
            if (mode == 0) bus.start = 1'b0;
            else if (mode == 2) bus.start = i[0];
            @(posedge clk);
        end
        if (mode != 1) bus.start = 1'b0;
        exp = sb.pop_front();
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", e, lat);
            chk("quotient", bus.quotient, exp.q);
            chk("remainder", bus.remainder, exp.r);
            chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, exp.dbz});
            @(negedge clk);
            chk("done_pulse_len", {31'd0, bus.done}, 32'd0);
            chk("busy_after", {31'd0, bus.busy}, 32'd0);
            chk("quotient_held", bus.quotient, exp.q);
        end
    endtask

    initial begin
        int stray;
        total     = 0;
        passed    = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b1;

        launch(32'd100, 32'd7, 0);
        launch(32'hFFFF_FFF9, 32'd2, 0);
        launch(32'd7, 32'hFFFF_FFFE, 0);
        launch(32'h8000_0000, 32'hFFFF_FFFF, 0);
        launch(32'd5, 32'd0, 0);
        launch(32'd9, 32'd3, 0);

        // Held start: one operation only, no relaunch after completion.
        launch(32'd50, 32'd5, 1);
        stray = 0;
        repeat (45) begin
            @(negedge clk);
            if (bus.done || bus.busy) stray++;
        end
        chk("held_start_no_relaunch", stray, 32'd0);
        bus.start = 1'b0;

        launch(32'd1234, 32'd17, 2);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.a     = 32'd777777;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_quotient", bus.quotient, 32'd0);
        chk("midrst_remainder", bus.remainder, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.quotient != 32'd0 || bus.remainder != 32'd0) stray++;
        end
        chk("after_rst_quiet", stray, 32'd0);

        launch(32'd1000, 32'd10, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
